// File: rtl/pwm_core.sv
// Single-channel PWM generator: integer clock divider feeding a 16-bit period
// counter with wrap-synchronised shadow registers for period and duty.
`timescale 1ns/1ps
module pwm_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] period,
  input  logic [15:0] duty_cycle,
  input  logic [15:0] divisor,
  input  logic        enable,
  output logic        pwm_out
);
  localparam int unsigned W = 16;

  logic         div_even;
  logic         div_odd;
  logic [W-1:0] even_half_m1;
  logic [W-1:0] even_cnt;
  logic         even_clk;
  logic [W:0]   odd_half_w;
  logic [W-1:0] odd_half;
  logic [W-1:0] odd_cnt;
  logic [W-1:0] odd_next;
  logic         p;
  logic         q;
  logic         odd_clk;
  logic         clk_div;

  logic [W-1:0] period_minus_1;
  logic [W-1:0] period_sh;
  logic [W-1:0] period_m1_sh;
  logic [W-1:0] duty_sh;
  logic [W-1:0] counter;
  logic         wrap;

  assign div_even     = (divisor >= W'(2)) && !divisor[0];
  assign div_odd      = (divisor >= W'(3)) && divisor[0];
  assign even_half_m1 = W'(divisor >> 1) - W'(1);
  // Widened so (N+1)/2 cannot overflow at N = 65535.
  assign odd_half_w   = ({1'b0, divisor} + (W+1)'(1)) >> 1;
  assign odd_half     = W'(odd_half_w);
  assign odd_next     = (odd_cnt >= divisor - W'(1)) ? '0 : odd_cnt + W'(1);

  // Even divider: toggle flop, >= compare tolerates N shrinking mid-count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      even_cnt <= '0;
      even_clk <= 1'b0;
    end else if (div_even) begin
      if (even_cnt >= even_half_m1) begin
        even_cnt <= '0;
        even_clk <= ~even_clk;
      end else begin
        even_cnt <= even_cnt + W'(1);
      end
    end else begin
      even_cnt <= '0;
      even_clk <= 1'b0;
    end
  end

  // Odd divider: p high for (N+1)/2 cycles, trimmed by half a cycle via q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      odd_cnt <= '0;
      p       <= 1'b0;
    end else if (div_odd) begin
      odd_cnt <= odd_next;
      p       <= (odd_next < odd_half);
    end else begin
      odd_cnt <= '0;
      p       <= 1'b0;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= p;
  end

  assign odd_clk = p & q;
  assign clk_div = div_odd ? odd_clk : (div_even ? even_clk : clk);

  assign period_minus_1 = period - W'(1);
  assign wrap           = (counter >= period_m1_sh);

  // Period counter and output; shadows reload while idle or at wrap.
  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      counter      <= '0;
      pwm_out      <= 1'b0;
      period_sh    <= '0;
      period_m1_sh <= '0;
      duty_sh      <= '0;
    end else if (!enable || period_sh == '0) begin
      // A zero period never wraps, so keep reloading to leave that state.
      counter      <= '0;
      pwm_out      <= 1'b0;
      period_sh    <= period;
      period_m1_sh <= period_minus_1;
      duty_sh      <= duty_cycle;
    end else begin
      counter <= wrap ? '0 : counter + W'(1);
      pwm_out <= (counter < duty_sh);
      if (wrap) begin
        period_sh    <= period;
        period_m1_sh <= period_minus_1;
        duty_sh      <= duty_cycle;
      end
    end
  end
endmodule

// File: tb/tb_pwm_core.sv
// Scoreboard bench for pwm_core: expected pulse widths are queued with the
// stimulus and popped as the monitor measures complete PWM periods.
`timescale 1ns/1ps
module tb_pwm_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] period = 16'd100;
  logic [15:0] duty_cycle = 16'd50;
  logic [15:0] divisor = 16'd1;
  logic        enable = 1'b0;
  logic        pwm_out;

  typedef struct {
    longint hi;
    longint per;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  bit     armed = 1'b0;

  pwm_core dut (
    .clk(clk), .reset(reset), .period(period), .duty_cycle(duty_cycle),
    .divisor(divisor), .enable(enable), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input longint hi, input longint per, input int n);
    exp_t e;
    e.hi = hi;
    e.per = per;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, longint'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  // Measures clk_div high time and period with 1 ns sampling (offset 0.5 ns).
  task automatic meas_div(output longint hi, output longint per);
    int  r0 = -1, f = -1, r1 = -1;
    logic prev, cur;
    #0.5;
    prev = dut.clk_div;
    for (int t = 1; t <= 300 && r1 < 0; t++) begin
      #1;
      cur = dut.clk_div;
      if (cur && !prev) begin
        if (r0 < 0) r0 = t;
        else if (f >= 0) r1 = t;
      end
      if (!cur && prev && r0 >= 0 && f < 0) f = t;
      prev = cur;
    end
    hi  = (r0 >= 0 && f >= 0) ? longint'(f - r0) : -1;
    per = (r0 >= 0 && r1 >= 0) ? longint'(r1 - r0) : -1;
  endtask

  // Monitor: pops one expectation per completed rise-to-rise PWM period.
  initial begin
    logic   prev = 1'b0;
    bit     have_rise = 1'b0, have_fall = 1'b0;
    longint t_rise = 0, t_fall = 0, now;
    exp_t   e;
    forever begin
      @(posedge clk);
      #1;
      now = longint'($time);
      if (!armed) begin
        have_rise = 1'b0;
        have_fall = 1'b0;
      end else begin
        if (pwm_out && !prev) begin
          if (have_rise && have_fall && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pwm_high_ns", t_fall - t_rise, e.hi);
            check("pwm_period_ns", now - t_rise, e.per);
          end
          have_rise = 1'b1;
          have_fall = 1'b0;
          t_rise = now;
        end
        if (!pwm_out && prev && have_rise) begin
          t_fall = now;
          have_fall = 1'b1;
        end
      end
      prev = pwm_out;
    end
  end

  initial begin
    longint hi, per;
    int     bad;

    // Reset state
    #12;
    check("rst_pwm", longint'(pwm_out), 0);
    check("rst_counter", longint'(dut.counter), 0);

    // Basic 50/100 at divide-by-1
    enable = 1'b1;
    #21 reset = 1'b1;
    armed = 1'b1;
    push(500, 1000, 3);
    wait_empty("basic", 600);

    // Duty change mid-period: current period completes unchanged
    #200 duty_cycle = 16'd75;
    push(500, 1000, 1);
    push(750, 1000, 2);
    wait_empty("duty", 500);

    // Period change mid-period
    #200 period = 16'd200;
    #1 check("period_minus_1", longint'(dut.period_minus_1), 199);
    push(750, 1000, 1);
    push(750, 2000, 2);
    wait_empty("period", 800);

    // Disable in high phase, hold, then re-enable from counter 0
    #200 armed = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    check("dis_pwm", longint'(pwm_out), 0);
    check("dis_counter", longint'(dut.counter), 0);
    repeat (10) @(posedge clk);
    #1 check("dis_hold_pwm", longint'(pwm_out), 0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("reen_pwm", longint'(pwm_out), 1);
    check("reen_counter", longint'(dut.counter), 1);
    armed = 1'b1;
    push(750, 2000, 2);
    wait_empty("reenable", 700);

    // Asynchronous reset in high phase, away from any clock edge
    #100 armed = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_pwm", longint'(pwm_out), 0);
    check("arst_counter", longint'(dut.counter), 0);
    #30 reset = 1'b1;
    armed = 1'b1;
    push(750, 2000, 2);
    wait_empty("after_reset", 700);

    // Divider: even and odd ratios
    armed = 1'b0;
    enable = 1'b0;
    period = 16'd4;
    duty_cycle = 16'd1;
    divisor = 16'd4;
    repeat (20) @(posedge clk);
    meas_div(hi, per);
    check("div4_high_ns", hi, 20);
    check("div4_period_ns", per, 40);
    divisor = 16'd3;
    repeat (20) @(posedge clk);
    meas_div(hi, per);
    check("div3_high_ns", hi, 15);
    check("div3_period_ns", per, 30);
    enable = 1'b1;
    armed = 1'b1;
    push(30, 120, 3);
    wait_empty("div3_pwm", 200);

    // Boundary: duty 0 gives constant low
    armed = 1'b0;
    enable = 1'b0;
    divisor = 16'd1;
    duty_cycle = 16'd0;
    repeat (5) @(posedge clk);
    enable = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pwm_out !== 1'b0) bad++;
    end
    check("duty0_high_samples", longint'(bad), 0);

    // Boundary: duty == period gives constant high
    enable = 1'b0;
    duty_cycle = 16'd4;
    repeat (5) @(posedge clk);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pwm_out !== 1'b1) bad++;
    end
    check("dutyfull_low_samples", longint'(bad), 0);

    // Boundary: period 1 keeps counter at 0 with output high
    enable = 1'b0;
    period = 16'd1;
    duty_cycle = 16'd1;
    repeat (5) @(posedge clk);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (pwm_out !== 1'b1 || dut.counter !== 16'd0) bad++;
    end
    check("period1_bad_samples", longint'(bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_core.md
# pwm_core

Configurable single-channel PWM generator for the peripheral timer subsystem. An integer clock divider produces an internal 50%-duty tick clock `clk_div`. A 16-bit period counter on `clk_div` compares against a duty threshold and drives one PWM output. Register-block outputs connect directly to `period`, `duty_cycle`, `divisor` and `enable`.

## Interface
- No parameters; all widths are fixed at 16 bits.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset. `reset`=0 clears all state immediately.
- `period`  input  16  PWM period, in `clk_div` cycles.
- `duty_cycle`  input  16  number of `clk_div` cycles per period that `pwm_out` is high.
- `divisor`  input  16  clock divide ratio N; 0 and 1 both mean divide-by-1.
- `enable`  input  1  1 runs the PWM; 0 forces idle.
- `pwm_out`  output  1  registered PWM output.

## Operation
- Divider, N = `divisor`:
  - N ≤ 1: `clk_div` = `clk`.
  - Even N ≥ 2: `even_clk` is a toggle flop on rising `clk`. It toggles each time its count reaches N/2−1, then the count returns to 0. Result: period N, 50% duty.
  - Odd N ≥ 3:
    - A rising-edge count runs 0..N−1.
    - Internal `p` is high while count < (N+1)/2.
    - Internal `q` is `p` resampled on falling `clk`.
    - `odd_clk` = `p` & `q`, which is high for N/2 `clk` periods.
  - `clk_div` = `odd_clk` when N is odd and ≥3, `even_clk` when N is even and ≥2, else `clk`.
  - Divider counters use a ≥ compare, so shrinking N on the fly cannot lock them up.
  - The divider runs regardless of `enable`.
- `period_minus_1` = `period` − 1, computed combinationally in 16 bits.
- Shadow registers `period_sh` and `duty_sh`:
  - Load from the inputs on every `clk_div` edge while `enable`=0.
  - While enabled, load only on the edge where `counter` wraps.
  - Changes therefore never glitch a running period.
- Counter, on each rising `clk_div` edge:
  - `enable`=0: `counter`←0, `pwm_out`←0.
  - `period_sh`=0: `counter`←0, `pwm_out`←0.
  - Otherwise: `counter`←(`counter` ≥ `period_sh`−1) ? 0 : `counter`+1.
  - Otherwise: `pwm_out`←(`counter` < `duty_sh`).
- Boundaries:
  - `duty_sh`=0: output constant 0.
  - `duty_sh` ≥ `period_sh`: output constant 1 while enabled.
  - `period`=1: `counter` stays 0, and `pwm_out` = (`duty_sh` ≥ 1).
- Internal `clk_div`, `even_clk`, `odd_clk`, `period_minus_1` and `counter` keep exactly these names so benches can probe them hierarchically.

## Timing
- Reset values (`reset`=0, asynchronous): `pwm_out`=0, `counter`=0, both shadows=0, all divider counters and `even_clk`/`p`/`q`=0.
- After reset release, the first `counter` update occurs on the first rising `clk_div` edge with `enable`=1.
- `pwm_out` lags the `counter` compare by one `clk_div` edge. This gives `duty_sh` high cycles, then `period_sh`−`duty_sh` low cycles, per period.
- Turning `enable` on:
  - The first high output appears on the first `clk_div` edge after `enable` is sampled 1.
  - `counter` is 0 at that point.
- Turning `enable` off: `pwm_out` reaches 0 within one `clk_div` edge.
- New `period`/`duty_cycle` values take effect at the next wrap (`counter` = `period_sh`−1 → 0); the new-value period starts one edge later.
- Reset mid-period: outputs clear without waiting for any clock edge. After release the PWM restarts from `counter`=0.
- Divisor change: takes effect within one old-N period plus one new-N period; the PWM counter is unaffected.

## Test plan
- Basic: `clk` 10 ns, `divisor`=1, `period`=100, `duty_cycle`=50, `enable`=1 → `pwm_out` high 500 ns, low 500 ns, repeating; `counter` cycles 0..99.
- Duty change mid-period: `duty_cycle` 50→75 → the current period completes at 50/50, then 750 ns high / 250 ns low.
- Period change: with duty 75, `period` 100→200 → after the next wrap, 750 ns high / 1250 ns low; `period_minus_1`=199.
- Disable: `enable`=0 → `pwm_out`=0 and `counter`=0 within 10 ns and held; re-enable resumes from `counter`=0.
- Async reset: `reset`=0 mid-high-phase → `pwm_out`=0 immediately, with no clock edge required; after release with `enable`=1, normal PWM resumes.
- Divider: `divisor`=4 → `clk_div` period 40 ns at 50% duty; `divisor`=3 → 30 ns period, high 15 ns. Check with `period`=4, `duty_cycle`=1 → `pwm_out` high 30 ns per 120 ns at `divisor`=3. Also check `duty_cycle`=0 → constant 0, and `duty_cycle`=`period` → constant 1.
